// File: rtl/node_mailbox_pkg.sv
// Shared constants for the node mailbox: address field positions, AXI response codes, FSM states.
package node_mailbox_pkg;

  // Address bit 31 (the MSB of a 32-bit bus) selects the mailbox window.
  localparam int INDEX_CONTROL = 31;
  localparam int INDEX_PROG    = 7;
  localparam int PICO_MSB      = 6;
  localparam int PICO_LSB      = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_RESP = 2'd1,
    ST_WR_DATA = 2'd2,
    ST_WR_RESP = 2'd3
  } mbx_state_e;

endpackage

// File: rtl/if_axi_light.sv
// Minimal AXI-lite style bus: single-beat read and write channels, no protection or IDs.
interface if_axi_light #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32
);
  logic                        awvalid;
  logic                        awready;
  logic [AXI_ADDR_WIDTH-1:0]   awaddr;
  logic                        wvalid;
  logic                        wready;
  logic [AXI_DATA_WIDTH-1:0]   wdata;
  logic [AXI_DATA_WIDTH/8-1:0] wstrb;
  logic                        bvalid;
  logic                        bready;
  logic [1:0]                  bresp;
  logic                        arvalid;
  logic                        arready;
  logic [AXI_ADDR_WIDTH-1:0]   araddr;
  logic                        rvalid;
  logic                        rready;
  logic [AXI_DATA_WIDTH-1:0]   rdata;
  logic [1:0]                  rresp;

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/node_mailbox_addr_decode.sv
// Combinational mailbox address decode: program-slot hit, busy-counter (stat) hit and node id.
module mailbox_addr_decode
  import node_mailbox_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int NODES  = 32
) (
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_hit,
  output logic              o_stat,
  output logic [4:0]        o_node_id
);
  logic w_in_range;
  logic w_unused_addr;

  assign o_node_id  = i_addr[PICO_MSB:PICO_LSB];
  assign w_in_range = (int'(o_node_id) < NODES);
  assign o_hit      = i_addr[ADDR_W-1] &  i_addr[INDEX_PROG] & w_in_range;
  assign o_stat     = i_addr[ADDR_W-1] & ~i_addr[INDEX_PROG] & w_in_range;

  assign w_unused_addr = ^{i_addr[ADDR_W-2:INDEX_PROG+1], i_addr[PICO_LSB-1:0]};
endmodule

// File: rtl/node_mailbox.sv
// Per-node task mailbox: scheduler loads program addresses, nodes poll and clear them over AXI-lite.
// Define NODE_MAILBOX_BUSY_CNT_EN to add per-node busy-cycle counters readable at addr[7]=0.
module node_mailbox
  import node_mailbox_pkg::*;
#(
  parameter int NODES          = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      res,
  if_axi_light.slave                s_axi,
  input  logic                      task_valid,
  input  logic [4:0]                task_node,
  input  logic [AXI_DATA_WIDTH-1:0] task_addr,
  output logic                      task_ready,
  output logic                      done_valid,
  output logic [4:0]                done_node,
  output logic [NODES-1:0]          slot_busy
);
  // state      | meaning
  // ST_IDLE    | ready for AR/AW (write wins a tie)
  // ST_RD_RESP | holding read response until rready
  // ST_WR_DATA | AW taken, waiting for W
  // ST_WR_RESP | holding write response until bready
`ifdef NODE_MAILBOX_BUSY_CNT_EN
  localparam bit CNT_EN = 1'b1;
  logic [31:0] r_cnt [32];
`else
  localparam bit CNT_EN = 1'b0;
`endif

  mbx_state_e                r_state;
  logic                      r_live;
  logic [AXI_DATA_WIDTH-1:0] r_slot [32];
  logic [AXI_DATA_WIDTH-1:0] w_slot_nxt [32];
  logic [31:0]               r_busy;
  logic                      r_wr_hit, r_wr_stat;
  logic [4:0]                r_wr_id;
  logic [AXI_DATA_WIDTH-1:0] r_rdata, w_rd_val;
  logic [1:0]                r_rresp, r_bresp;
  logic                      r_done_valid;
  logic [4:0]                r_done_node;
  logic                      w_ar_hit, w_ar_stat, w_aw_hit, w_aw_stat;
  logic [4:0]                w_ar_id, w_aw_id, w_clr_id;
  logic                      w_idle, w_aw_fire, w_w_now, w_w_fire, w_ar_fire;
  logic                      w_clr_hit, w_clr_busy, w_task_in_range, w_load;
  logic                      w_unused_wdata;

  mailbox_addr_decode #(.ADDR_W(AXI_ADDR_WIDTH), .NODES(NODES)) u_ar_dec (
    .i_addr(s_axi.araddr), .o_hit(w_ar_hit), .o_stat(w_ar_stat), .o_node_id(w_ar_id)
  );
  mailbox_addr_decode #(.ADDR_W(AXI_ADDR_WIDTH), .NODES(NODES)) u_aw_dec (
    .i_addr(s_axi.awaddr), .o_hit(w_aw_hit), .o_stat(w_aw_stat), .o_node_id(w_aw_id)
  );

  function automatic logic [1:0] resp_of(input logic hit, input logic stat);
    return (hit | (stat & CNT_EN)) ? RESP_OKAY : RESP_DECERR;
  endfunction

  // r_live keeps every ready low while reset is held.
  assign w_idle    = r_live & (r_state == ST_IDLE);
  assign w_aw_fire = w_idle & s_axi.awvalid;
  assign w_w_now   = w_aw_fire & s_axi.wvalid;
  assign w_w_fire  = w_w_now | ((r_state == ST_WR_DATA) & s_axi.wvalid);
  assign w_ar_fire = w_idle & ~s_axi.awvalid & s_axi.arvalid;
  assign w_clr_hit = w_w_now ? w_aw_hit : r_wr_hit;
  assign w_clr_id  = w_w_now ? w_aw_id  : r_wr_id;
  assign w_clr_busy = w_w_fire & w_clr_hit & (r_slot[w_clr_id] != '0);

  assign w_task_in_range = (int'(task_node) < NODES);
  assign task_ready = r_live & (~w_task_in_range | (r_slot[task_node] == '0));
  assign w_load     = task_valid & task_ready & w_task_in_range & (task_addr != '0);

  // Write data is a don't-care: any write hit simply clears the slot.
  assign w_unused_wdata = ^{s_axi.wdata, s_axi.wstrb};

  always_comb begin
    w_rd_val = '0;
    if (w_ar_hit) w_rd_val = r_slot[w_ar_id];
`ifdef NODE_MAILBOX_BUSY_CNT_EN
    else if (w_ar_stat) w_rd_val = AXI_DATA_WIDTH'(r_cnt[w_ar_id]);
`endif
  end

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      w_slot_nxt[i] = r_slot[i];
      if (w_w_fire && w_clr_hit && (w_clr_id == 5'(i))) w_slot_nxt[i] = '0;
      if (w_load && (task_node == 5'(i))) w_slot_nxt[i] = task_addr;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      for (int i = 0; i < 32; i++) r_slot[i] <= '0;
      r_busy <= '0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        r_slot[i] <= w_slot_nxt[i];
        r_busy[i] <= |w_slot_nxt[i];
      end
    end
  end

`ifdef NODE_MAILBOX_BUSY_CNT_EN
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      for (int i = 0; i < 32; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (w_load && (task_node == 5'(i))) r_cnt[i] <= '0;
        else if (r_busy[i])                 r_cnt[i] <= r_cnt[i] + 32'd1;
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state      <= ST_IDLE;
      r_live       <= 1'b0;
      r_wr_hit     <= 1'b0;
      r_wr_stat    <= 1'b0;
      r_wr_id      <= '0;
      r_rdata      <= '0;
      r_rresp      <= RESP_OKAY;
      r_bresp      <= RESP_OKAY;
      r_done_valid <= 1'b0;
      r_done_node  <= '0;
    end else begin
      r_live       <= 1'b1;
      r_done_valid <= w_clr_busy;
      if (w_clr_busy) r_done_node <= w_clr_id;
      case (r_state)
        ST_IDLE: begin
          if (w_aw_fire) begin
            r_wr_hit  <= w_aw_hit;
            r_wr_stat <= w_aw_stat;
            r_wr_id   <= w_aw_id;
            if (s_axi.wvalid) begin
              r_bresp <= resp_of(w_aw_hit, w_aw_stat);
              r_state <= ST_WR_RESP;
            end else begin
              r_state <= ST_WR_DATA;
            end
          end else if (w_ar_fire) begin
            r_rdata <= w_rd_val;
            r_rresp <= resp_of(w_ar_hit, w_ar_stat);
            r_state <= ST_RD_RESP;
          end
        end
        ST_WR_DATA: if (s_axi.wvalid) begin
          r_bresp <= resp_of(r_wr_hit, r_wr_stat);
          r_state <= ST_WR_RESP;
        end
        ST_RD_RESP: if (s_axi.rready) r_state <= ST_IDLE;
        ST_WR_RESP: if (s_axi.bready) r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_axi.arready = w_idle;
  assign s_axi.awready = w_idle;
  assign s_axi.wready  = w_idle | (r_state == ST_WR_DATA);
  assign s_axi.rvalid  = (r_state == ST_RD_RESP);
  assign s_axi.bvalid  = (r_state == ST_WR_RESP);
  assign s_axi.rdata   = r_rdata;
  assign s_axi.rresp   = r_rresp;
  assign s_axi.bresp   = r_bresp;
  assign done_valid    = r_done_valid;
  assign done_node     = r_done_node;
  assign slot_busy     = r_busy[NODES-1:0];
endmodule

// File: tb/tb_node_mailbox.sv
// Directed scoreboard bench for node_mailbox with NODES=4: loads, polls, clears, races and reset abort.
module tb_node_mailbox;
  import node_mailbox_pkg::*;

  localparam int NODES = 4;

  logic             clk = 1'b0;
  logic             res = 1'b1;
  logic             task_valid = 1'b0;
  logic [4:0]       task_node  = '0;
  logic [31:0]      task_addr  = '0;
  logic             task_ready, done_valid;
  logic [4:0]       done_node;
  logic [NODES-1:0] slot_busy;

  always #5 clk = ~clk;

  if_axi_light #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32)) axi ();

  node_mailbox #(.NODES(NODES), .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32)) dut (
    .clk(clk), .res(res), .s_axi(axi),
    .task_valid(task_valid), .task_node(task_node), .task_addr(task_addr),
    .task_ready(task_ready), .done_valid(done_valid), .done_node(done_node),
    .slot_busy(slot_busy)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_done   = 0;
  int          exp_done = 0;
  logic [33:0] rd_q [$];   // {rdata, rresp}
  logic [1:0]  wr_q [$];
  logic [4:0]  done_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!res && done_valid === 1'b1) begin
      n_done++;
      check("done_pending", 32'(done_q.size() > 0), 32'd1);
      if (done_q.size() > 0) check("done_node", 32'(done_node), 32'(done_q.pop_front()));
    end
  end

  function automatic logic [31:0] node_addr(input int id, input bit prog);
    return 32'h8000_0000 | (prog ? 32'h80 : 32'h0) | (32'(id) << 2);
  endfunction

  task automatic load(input logic [4:0] node, input logic [31:0] addr);
    task_valid = 1'b1; task_node = node; task_addr = addr;
    @(negedge clk);
    task_valid = 1'b0;
  endtask

  task automatic rd_collect(input string tag);
    logic [33:0] e;
    int t = 0;
    axi.rready = 1'b1;
    while (axi.rvalid !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    check({tag, "_rvalid"}, 32'(axi.rvalid), 32'd1);
    e = rd_q.pop_front();
    check({tag, "_rdata"}, axi.rdata, e[33:2]);
    check({tag, "_rresp"}, 32'(axi.rresp), 32'(e[1:0]));
    @(negedge clk);
    axi.rready = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp_data,
                    input logic [1:0] exp_resp, input string tag);
    int t = 0;
    rd_q.push_back({exp_data, exp_resp});
    axi.araddr = addr; axi.arvalid = 1'b1;
    while (axi.arready !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    check({tag, "_arready"}, 32'(axi.arready), 32'd1);
    @(negedge clk);
    axi.arvalid = 1'b0;
    rd_collect(tag);
  endtask

  task automatic wr_collect(input string tag);
    int t = 0;
    axi.bready = 1'b1;
    while (axi.bvalid !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    check({tag, "_bvalid"}, 32'(axi.bvalid), 32'd1);
    check({tag, "_bresp"}, 32'(axi.bresp), 32'(wr_q.pop_front()));
    @(negedge clk);
    axi.bready = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input int wdelay, input logic [1:0] exp_resp,
                    input string tag);
    int t = 0;
    wr_q.push_back(exp_resp);
    axi.awaddr = addr; axi.awvalid = 1'b1;
    axi.wdata = 32'hDEAD_BEEF; axi.wstrb = 4'hF; axi.wvalid = (wdelay == 0);
    while (axi.awready !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    check({tag, "_awready"}, 32'(axi.awready), 32'd1);
    @(negedge clk);
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    if (wdelay > 0) begin
      repeat (wdelay - 1) @(negedge clk);
      axi.wvalid = 1'b1;
      check({tag, "_wready"}, 32'(axi.wready), 32'd1);
      @(negedge clk);
      axi.wvalid = 1'b0;
    end
    wr_collect(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    axi.awvalid = 1'b0; axi.awaddr = '0; axi.wvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0;
    axi.bready = 1'b0; axi.arvalid = 1'b0; axi.araddr = '0; axi.rready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_task_ready", 32'(task_ready), 32'd0);
    check("rst_arready", 32'(axi.arready), 32'd0);
    check("rst_rvalid", 32'(axi.rvalid), 32'd0);
    check("rst_bvalid", 32'(axi.bvalid), 32'd0);
    check("rst_rdata", axi.rdata, 32'd0);
    check("rst_done", 32'(done_valid), 32'd0);
    check("rst_slot_busy", 32'(slot_busy), 32'd0);
    res = 1'b0;
    @(negedge clk);
    check("idle_arready", 32'(axi.arready), 32'd1);
    check("idle_awready", 32'(axi.awready), 32'd1);
    check("idle_wready", 32'(axi.wready), 32'd1);

    task_node = 5'd3;
    check("task_ready_empty", 32'(task_ready), 32'd1);
    load(5'd3, 32'h0001_0000);
    check("busy_after_load3", 32'(slot_busy), 32'h8);
    rd(node_addr(3, 1), 32'h0001_0000, RESP_OKAY, "rd_node3");

    task_valid = 1'b1; task_node = 5'd3; task_addr = 32'h2222;
    check("task_ready_busy", 32'(task_ready), 32'd0);
    @(negedge clk);
    task_valid = 1'b0;
    rd(node_addr(3, 1), 32'h0001_0000, RESP_OKAY, "rd_node3_kept");
    rd(node_addr(5, 1), 32'h0, RESP_DECERR, "rd_miss5");

    done_q.push_back(5'd3); exp_done++;
    wr(node_addr(3, 1), 0, RESP_OKAY, "wr_clr3");
    check("busy_after_clr3", 32'(slot_busy), 32'h0);
    rd(node_addr(3, 1), 32'h0, RESP_OKAY, "rd_node3_cleared");
    wr(node_addr(1, 1), 2, RESP_OKAY, "wr_empty1");
    check("done_count_empty_wr", 32'(n_done), 32'(exp_done));

    // AR and AW in the same cycle: write must be answered first.
    load(5'd1, 32'hABCD_0000);
    load(5'd2, 32'h0000_1234);
    axi.araddr = node_addr(1, 1); axi.arvalid = 1'b1;
    axi.awaddr = node_addr(2, 1); axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    rd_q.push_back({32'hABCD_0000, RESP_OKAY});
    done_q.push_back(5'd2); exp_done++;
    @(negedge clk);
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    check("race_bvalid", 32'(axi.bvalid), 32'd1);
    check("race_rvalid_held_off", 32'(axi.rvalid), 32'd0);
    check("race_bresp", 32'(axi.bresp), 32'(RESP_OKAY));
    axi.bready = 1'b1;
    @(negedge clk);
    axi.bready = 1'b0;
    check("race_rvalid_after_b", 32'(axi.rvalid), 32'd0);
    @(negedge clk);
    axi.arvalid = 1'b0;
    rd_collect("race_rd");
    check("busy_after_race", 32'(slot_busy), 32'h2);

    // Clear of node 1 concurrent with load of node 0.
    axi.awaddr = node_addr(1, 1); axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    task_valid = 1'b1; task_node = 5'd0; task_addr = 32'h0000_5000;
    wr_q.push_back(RESP_OKAY);
    done_q.push_back(5'd1); exp_done++;
    @(negedge clk);
    axi.awvalid = 1'b0; axi.wvalid = 1'b0; task_valid = 1'b0;
    check("busy_load_and_clear", 32'(slot_busy), 32'h1);
    wr_collect("wr_clr1_load0");
    rd(node_addr(0, 1), 32'h0000_5000, RESP_OKAY, "rd_node0");

    // Load landing in the AR acceptance cycle: read sees the old value.
    axi.araddr = node_addr(2, 1); axi.arvalid = 1'b1;
    task_valid = 1'b1; task_node = 5'd2; task_addr = 32'h0000_7777;
    rd_q.push_back({32'h0, RESP_OKAY});
    @(negedge clk);
    axi.arvalid = 1'b0; task_valid = 1'b0;
    rd_collect("rd_old_value");
    rd(node_addr(2, 1), 32'h0000_7777, RESP_OKAY, "rd_new_value");
    check("busy_0_and_2", 32'(slot_busy), 32'h5);

`ifdef NODE_MAILBOX_BUSY_CNT_EN
    load(5'd1, 32'h0000_0100);
    repeat (99) @(negedge clk);
    done_q.push_back(5'd1); exp_done++;
    wr(node_addr(1, 1), 0, RESP_OKAY, "wr_clr1_cnt");
    rd(node_addr(1, 0), 32'd100, RESP_OKAY, "rd_busy_cnt1");
`else
    rd(node_addr(1, 0), 32'h0, RESP_DECERR, "rd_stat_off");
    wr(node_addr(2, 0), 0, RESP_DECERR, "wr_stat_off");
    check("busy_after_stat_wr", 32'(slot_busy), 32'h5);
`endif

    // Reset while a read response is being held.
    axi.araddr = node_addr(0, 1); axi.arvalid = 1'b1;
    @(negedge clk);
    axi.arvalid = 1'b0;
    check("abort_rvalid_held", 32'(axi.rvalid), 32'd1);
    #2 res = 1'b1;
    @(negedge clk);
    check("abort_rvalid", 32'(axi.rvalid), 32'd0);
    check("abort_slot_busy", 32'(slot_busy), 32'h0);
    check("abort_task_ready", 32'(task_ready), 32'd0);
    res = 1'b0;
    axi.rready = 1'b1;
    repeat (3) @(negedge clk);
    axi.rready = 1'b0;
    check("abort_no_rvalid", 32'(axi.rvalid), 32'd0);
    check("abort_done_count", 32'(n_done), 32'(exp_done));
    rd(node_addr(0, 1), 32'h0, RESP_OKAY, "rd_after_abort");

    check("rd_q_drained", 32'(rd_q.size()), 32'd0);
    check("wr_q_drained", 32'(wr_q.size()), 32'd0);
    check("done_q_drained", 32'(done_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
